multicycle_ctrl: RTL and testbench

Sequencing control unit for the multicycle RV32I core. It replaces the single-cycle opcode decoder with a Moore state machine that steps each instruction through fetch, decode, execute, memory and writeback. Memory accesses use a ready handshake guarded by a timeout. It sits between the instruction register (opcode/func3 fields) and the shared-memory datapath, driving every mux select and write enable.

---
 rtl/riscv_ctrl_pkg.sv | 57 +++++
 rtl/mem_wait_timer.sv | 41 ++++
 rtl/multicycle_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Purpose: shared encodings for the multicycle RV32I sequencing controller.
// Latency: n/a (types, constants and a combinational dispatch helper only).
// Backpressure: n/a.
package riscv_ctrl_pkg;

    // Major opcodes (IR[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // func3 values this core implements
    localparam logic [2:0] F3_ADDI = 3'b000;
    localparam logic [2:0] F3_SLLI = 3'b001;
    localparam logic [2:0] F3_SLTI = 3'b010;
    localparam logic [2:0] F3_ANDI = 3'b111;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_JALR = 3'b000;

    // Order fixes the debug encoding seen on the state port.
    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXEC_R,
        S_EXEC_I, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_AUIPC, S_LUI, S_HALT
    } state_e;

    typedef enum logic [1:0] {SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RS1 = 2'b10, SRCA_ZERO = 2'b11} alu_src_a_e;
    typedef enum logic [1:0] {SRCB_RS2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10} alu_src_b_e;
    typedef enum logic [1:0] {RES_ALUOUT = 2'b00, RES_MEM = 2'b01, RES_ALU = 2'b10, RES_LINK = 2'b11} result_src_e;
    typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNC = 2'b10} alu_op_e;

    // States that drive a memory access and so wait on mem_ready.
    function automatic logic is_mem_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

    // DECODE dispatch; anything unsupported lands in HALT.
    function automatic state_e dispatch(input logic [6:0] op, input logic [2:0] f3, input bit lui_en);
        case (op)
            OP_LOAD, OP_STORE: return S_MEMADR;
            OP_RTYPE:          return S_EXEC_R;
            OP_ITYPE:          return (f3 inside {F3_ADDI, F3_ANDI, F3_SLLI, F3_SLTI}) ? S_EXEC_I : S_HALT;
            OP_BRANCH:         return (f3 inside {F3_BEQ, F3_BNE}) ? S_BRANCH : S_HALT;
            OP_JAL:            return S_JAL;
            OP_JALR:           return (f3 == F3_JALR) ? S_JALR : S_HALT;
            OP_AUIPC:          return S_AUIPC;
            OP_LUI:            return lui_en ? S_LUI : S_HALT;
            default:           return S_HALT;
        endcase
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Purpose: counts cycles spent in a memory state and flags the last permitted one.
// Latency: expired is a decode of the registered count (same cycle as the count).
// Backpressure: none; clear has priority over count_en.
module mem_wait_timer #(
    parameter int TIMEOUT_W = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam logic [TIMEOUT_W-1:0] CNT_ONES = '1;
    // The cycle holding this count is the (2^W-1)th waiting cycle.
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = CNT_ONES - TIMEOUT_W'(1);

    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

    // Clear on state change, otherwise advance once per waiting cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (count_en) begin
            cnt_d = cnt_q + TIMEOUT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == CNT_LAST);

endmodule

// File: rtl/multicycle_ctrl.sv
// Purpose: Moore sequencer stepping RV32I instructions through fetch/decode/execute/memory/writeback.
// Latency: 3-5 cycles per instruction with zero-wait memory; outputs decode from the state register.
// Backpressure: memory states stall on mem_ready=0 and fall into HALT with bus_error after 2^TIMEOUT_W-1 waits.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter int TIMEOUT_W     = 8,
    parameter bit SUPPORT_LUI   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] opcode,
    input  logic [2:0] func3,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       ir_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       reg_write,
    output logic       branch,
    output logic       branch_ne,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [1:0] alu_op,
    output logic       halted,
    output logic       bus_error,
    output logic [3:0] state
);

    state_e state_q, state_d;
    logic   branch_ne_q, branch_ne_d;
    logic   bus_error_q, bus_error_d;
    logic   ready;
    logic   tmr_clear, tmr_count_en, tmr_expired;

    assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

    // Wait counter restarts on every state change, so each memory state gets a fresh budget.
    assign tmr_clear    = (state_d != state_q);
    assign tmr_count_en = is_mem_state(state_q) && !ready;

    mem_wait_timer #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (tmr_clear),
        .count_en (tmr_count_en),
        .expired  (tmr_expired)
    );

    // Next-state logic; ready beats a simultaneous timeout.
    always_comb begin
        state_d     = state_q;
        branch_ne_d = branch_ne_q;
        bus_error_d = bus_error_q;
        case (state_q)
            S_IDLE:     if (start) state_d = S_FETCH;
            S_FETCH: begin
                if (ready) begin
                    state_d = S_DECODE;
                end else if (tmr_expired) begin
                    state_d     = S_HALT;
                    bus_error_d = 1'b1;
                end
            end
            S_DECODE: begin
                branch_ne_d = func3[0];
                state_d     = dispatch(opcode, func3, SUPPORT_LUI);
            end
            // opcode[5] separates store from load; the IR is stable here.
            S_MEMADR:   state_d = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
                if (ready) begin
                    state_d = S_MEMWB;
                end else if (tmr_expired) begin
                    state_d     = S_HALT;
                    bus_error_d = 1'b1;
                end
            end
            S_MEMWRITE: begin
                if (ready) begin
                    state_d = S_FETCH;
                end else if (tmr_expired) begin
                    state_d     = S_HALT;
                    bus_error_d = 1'b1;
                end
            end
            S_EXEC_R, S_EXEC_I, S_AUIPC, S_LUI:     state_d = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_JAL, S_JALR: state_d = S_FETCH;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_HALT;
        endcase
    end

    // State, latched branch sense and sticky bus error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            branch_ne_q <= 1'b0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            branch_ne_q <= branch_ne_d;
            bus_error_q <= bus_error_d;
        end
    end

    // Moore output decode; only the FETCH write enables also look at ready.
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RS2;
        result_src = RES_ALUOUT;
        alu_op     = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = ready;
                pc_write  = ready;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: begin
                mem_read = 1'b1;
                adr_src  = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                result_src = RES_MEM;
            end
            S_MEMWRITE: begin
                mem_write = 1'b1;
                adr_src   = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALU_FUNC;
            end
            S_EXEC_I: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_FUNC;
            end
            S_ALUWB:    reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = SRCA_RS1;
                alu_op    = ALU_SUB;
                branch    = 1'b1;
            end
            // PC loads the target already in ALUOut from DECODE; the one
            // result_src select is spent on the link value written to rd.
            S_JAL: begin
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                result_src = RES_LINK;
            end
            S_JALR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                pc_write   = 1'b1;
                reg_write  = 1'b1;
                result_src = RES_LINK;
            end
            S_AUIPC: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
            end
            S_LUI: begin
                alu_src_a = SRCA_ZERO;
                alu_src_b = SRCB_IMM;
            end
            default: ;
        endcase
    end

    assign branch_ne = branch_ne_q;
    assign bus_error = bus_error_q;
    assign halted    = (state_q == S_HALT);
    assign state     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    // Debug state numbering follows the order the states are listed in the block description.
    localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_MEMADR = 3, S_MEMREAD = 4,
                   S_MEMWB = 5, S_MEMWRITE = 6, S_EXEC_R = 7, S_EXEC_I = 8, S_ALUWB = 9,
                   S_BRANCH = 10, S_JAL = 11, S_JALR = 12, S_AUIPC = 13, S_LUI = 14, S_HALT = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (default parameters)
    logic       reset, start, mem_ready;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic       pc_write, ir_write, mem_read, mem_write, reg_write, branch, branch_ne, adr_src;
    logic [1:0] alu_src_a, alu_src_b, result_src, alu_op;
    logic       halted, bus_error;
    logic [3:0] state;

    multicycle_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .opcode(opcode), .func3(func3),
        .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .branch(branch), .branch_ne(branch_ne),
        .adr_src(adr_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .result_src(result_src),
        .alu_op(alu_op), .halted(halted), .bus_error(bus_error), .state(state)
    );

    // Short-timeout DUT
    logic       reset2, start2, ready2;
    logic       pcw2, irw2, mr2, mw2, rw2, br2, bne2, as2, halted2, berr2;
    logic [1:0] a2, b2, rs2, op2;
    logic [3:0] state2;

    multicycle_ctrl #(.TIMEOUT_W(2)) dut_t (
        .clk(clk), .reset(reset2), .start(start2), .opcode(opcode), .func3(func3),
        .mem_ready(ready2), .pc_write(pcw2), .ir_write(irw2), .mem_read(mr2),
        .mem_write(mw2), .reg_write(rw2), .branch(br2), .branch_ne(bne2),
        .adr_src(as2), .alu_src_a(a2), .alu_src_b(b2), .result_src(rs2),
        .alu_op(op2), .halted(halted2), .bus_error(berr2), .state(state2)
    );

    logic [21:0] dv;
    assign dv = {pc_write, ir_write, mem_read, mem_write, reg_write, branch, branch_ne, adr_src,
                 alu_src_a, alu_src_b, result_src, alu_op, halted, bus_error, state};

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected output vector for one cycle, straight from the per-state output list.
    function automatic logic [21:0] ev(input int st, input logic rdy, input logic bne, input logic berr);
        logic pcw = 0, irw = 0, mr = 0, mw = 0, rw = 0, br = 0, as = 0, hl = 0;
        logic [1:0] a = 0, b = 0, rs = 0, op = 0;
        case (st)
            S_FETCH:    begin mr = 1; b = 2'b10; irw = rdy; pcw = rdy; end
            S_DECODE:   begin a = 2'b01; b = 2'b01; end
            S_MEMADR:   begin a = 2'b10; b = 2'b01; end
            S_MEMREAD:  begin mr = 1; as = 1; end
            S_MEMWB:    begin rw = 1; rs = 2'b01; end
            S_MEMWRITE: begin mw = 1; as = 1; end
            S_EXEC_R:   begin a = 2'b10; op = 2'b10; end
            S_EXEC_I:   begin a = 2'b10; b = 2'b01; op = 2'b10; end
            S_ALUWB:    rw = 1;
            S_BRANCH:   begin a = 2'b10; op = 2'b01; br = 1; end
            S_JAL:      begin pcw = 1; rw = 1; rs = 2'b11; end
            S_JALR:     begin a = 2'b10; b = 2'b01; pcw = 1; rw = 1; rs = 2'b11; end
            S_AUIPC:    begin a = 2'b01; b = 2'b01; end
            S_LUI:      begin a = 2'b11; b = 2'b01; end
            S_HALT:     hl = 1;
            default:    ;
        endcase
        return {pcw, irw, mr, mw, rw, br, bne, as, a, b, rs, op, hl, berr, 4'(st)};
    endfunction

    typedef struct {
        logic        rdy;
        logic [21:0] vec;
    } step_t;

    step_t      q[$];
    logic       bne_m = 1'b0;
    logic [6:0] cur_op;
    logic [2:0] cur_f3;
    int         n_rw, n_mr;
    logic [3:0] br_obs;
    logic [1:0] rs_rw;

    // Non-memory states get a random mem_ready: it must be ignored there.
    task automatic push(input int st, input logic rdy);
        step_t s;
        s.rdy = rdy;
        s.vec = ev(st, rdy, bne_m, 1'b0);
        q.push_back(s);
    endtask

    task automatic push_any(input int st);
        push(st, 1'($urandom_range(0, 1)));
    endtask

    // Instruction-level model: expected cycle trace for one instruction.
    task automatic build(input logic [6:0] op, input logic [2:0] f3, input int fw, input int mw);
        for (int i = 0; i < fw; i++) push(S_FETCH, 1'b0);
        push(S_FETCH, 1'b1);
        push_any(S_DECODE);
        bne_m = f3[0];
        case (op)
            7'b0000011: begin
                push_any(S_MEMADR);
                for (int i = 0; i < mw; i++) push(S_MEMREAD, 1'b0);
                push(S_MEMREAD, 1'b1);
                push_any(S_MEMWB);
            end
            7'b0100011: begin
                push_any(S_MEMADR);
                for (int i = 0; i < mw; i++) push(S_MEMWRITE, 1'b0);
                push(S_MEMWRITE, 1'b1);
            end
            7'b0110011: begin push_any(S_EXEC_R); push_any(S_ALUWB); end
            7'b0010011: begin
                if (f3 == 3'd0 || f3 == 3'd7 || f3 == 3'd1 || f3 == 3'd2) begin
                    push_any(S_EXEC_I); push_any(S_ALUWB);
                end else begin
                    for (int i = 0; i < 3; i++) push_any(S_HALT);
                end
            end
            7'b1100011: begin
                if (f3 <= 3'd1) push_any(S_BRANCH);
                else for (int i = 0; i < 3; i++) push_any(S_HALT);
            end
            7'b1101111: push_any(S_JAL);
            7'b1100111: begin
                if (f3 == 3'd0) push_any(S_JALR);
                else for (int i = 0; i < 3; i++) push_any(S_HALT);
            end
            7'b0010111: begin push_any(S_AUIPC); push_any(S_ALUWB); end
            7'b0110111: begin push_any(S_LUI); push_any(S_ALUWB); end
            default: for (int i = 0; i < 3; i++) push_any(S_HALT);
        endcase
    endtask

    // The single compare point: drive at negedge, check 1 time unit later.
    task automatic play(input int n);
        step_t s;
        for (int k = 0; k < n; k++) begin
            s = q.pop_front();
            @(negedge clk);
            mem_ready = s.rdy;
            opcode    = cur_op;
            func3     = cur_f3;
            #1;
            chk($sformatf("cycle op=%b step=%0d", cur_op, k), 32'(dv), 32'(s.vec));
            if (reg_write) begin
                n_rw++;
                rs_rw = result_src;
            end
            if (state == 4'(S_MEMREAD)) n_mr++;
            if (state == 4'(S_BRANCH)) br_obs = {branch, branch_ne, alu_op};
            @(posedge clk);
        end
        q.delete();
    endtask

    task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input int fw, input int mw,
                             input int exp_len);
        cur_op = op;
        cur_f3 = f3;
        build(op, f3, fw, mw);
        chk($sformatf("len op=%b", op), 32'(q.size()), 32'(exp_len));
        n_rw   = 0;
        n_mr   = 0;
        br_obs = '0;
        rs_rw  = '0;
        play(q.size());
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        start     = 1'b0;
        mem_ready = 1'b0;
        #1;
        chk("reset_outputs", 32'(dv), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bne_m = 1'b0;
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        #1;
        chk("idle_before_start", 32'(dv), 32'd0);
        @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
        $fatal(1);
    end

    initial begin
        reset = 1'b1; start = 1'b0; mem_ready = 1'b0; opcode = '0; func3 = '0;
        reset2 = 1'b1; start2 = 1'b0; ready2 = 1'b0;
        cur_op = '0; cur_f3 = '0;

        do_reset();
        // One idle cycle without start stays in IDLE.
        @(negedge clk); #1;
        chk("idle_hold", 32'(state), 32'(S_IDLE));
        do_start();   // start stays high from here on and must be ignored

        run_instr(7'b0110011, 3'b000, 0, 0, 4);           // R-type
        chk("rtype_reg_write_cycles", 32'(n_rw), 32'd1);
        run_instr(7'b0000011, 3'b010, 1, 3, 9);           // load, 1 fetch wait, 3 mem waits
        chk("load_memread_cycles", 32'(n_mr), 32'd4);
        chk("load_reg_write_cycles", 32'(n_rw), 32'd1);
        chk("load_result_src", 32'(rs_rw), 32'd1);
        run_instr(7'b0100011, 3'b010, 0, 2, 6);           // store, 2 mem waits
        run_instr(7'b0010011, 3'b111, 0, 0, 4);           // ANDI
        run_instr(7'b1100011, 3'b001, 0, 0, 3);           // BNE
        chk("bne_branch_cycle", 32'(br_obs), 32'b1101);
        run_instr(7'b1100011, 3'b000, 0, 0, 3);           // BEQ
        chk("beq_branch_cycle", 32'(br_obs), 32'b1001);
        run_instr(7'b1101111, 3'b000, 0, 0, 3);           // JAL
        run_instr(7'b1100111, 3'b000, 0, 0, 3);           // JALR
        run_instr(7'b0010111, 3'b101, 0, 0, 4);           // AUIPC
        run_instr(7'b0110111, 3'b000, 0, 0, 4);           // LUI
        run_instr(7'b0010011, 3'b101, 0, 0, 5);           // illegal I-type func3
        chk("illegal_f3_halted", 32'(halted), 32'd1);
        chk("illegal_f3_bus_error", 32'(bus_error), 32'd0);

        do_reset();
        do_start();
        run_instr(7'b0000000, 3'b000, 0, 0, 5);           // illegal opcode
        chk("illegal_op_state", 32'(state), 32'(S_HALT));
        chk("illegal_op_bus_error", 32'(bus_error), 32'd0);

        // Asynchronous reset while a store waits in MEMWRITE.
        do_reset();
        do_start();
        cur_op = 7'b0100011;
        cur_f3 = 3'b010;
        build(cur_op, cur_f3, 0, 5);
        play(4);
        #2;
        chk("mem_write_before_reset", 32'(mem_write), 32'd1);
        reset = 1'b1;
        #1;
        chk("mem_write_async_drop", 32'(mem_write), 32'd0);
        chk("state_async_idle", 32'(state), 32'(S_IDLE));
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;

        // Short timeout: three waiting cycles in FETCH, then HALT with bus_error.
        @(negedge clk);
        reset2 = 1'b0; start2 = 1'b1; ready2 = 1'b0;
        @(posedge clk);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk); #1;
            chk($sformatf("to_wait%0d_state", i), 32'(state2), 32'(S_FETCH));
            chk($sformatf("to_wait%0d_irw", i), 32'(irw2), 32'd0);
            @(posedge clk);
        end
        @(negedge clk); #1;
        chk("to_halt_state", 32'(state2), 32'(S_HALT));
        chk("to_bus_error", 32'(berr2), 32'd1);
        chk("to_halted", 32'(halted2), 32'd1);

        // Ready on the third waiting cycle wins over the timeout.
        @(negedge clk);
        reset2 = 1'b1;
        @(negedge clk);
        reset2 = 1'b0;
        @(posedge clk);
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk); #1;
            chk($sformatf("rdy_wait%0d_state", i), 32'(state2), 32'(S_FETCH));
            @(posedge clk);
        end
        @(negedge clk);
        ready2 = 1'b1;
        #1;
        chk("rdy_third_irw_pcw", 32'({irw2, pcw2}), 32'b11);
        @(posedge clk);
        @(negedge clk);
        ready2 = 1'b0;
        #1;
        chk("rdy_third_decode", 32'(state2), 32'(S_DECODE));
        chk("rdy_third_no_error", 32'(berr2), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
